// File: rtl/rf_spill_fill.sv
// rtl/rf_spill_fill.sv - register-window spill/fill engine between a register file and word streams
module rf_spill_fill #(
    parameter int WIDTH = 16,
    parameter int REGS  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [1:0]       win,
    output logic             busy,
    output logic             done,
    output logic [1:0]       rf_wrap,
    output logic [1:0]       rf_ra1,
    input  logic [WIDTH-1:0] rf_rd1,
    output logic [1:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             rf_we,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LAST = 2'(REGS - 1);

    state_t     state;
    logic [1:0] idx;
    logic       spill_hs;

    // Read data passes straight through; idx only moves on a handshake, so a stalled word holds.
    assign spill_hs = out_valid && out_ready;
    assign rf_we    = in_valid && in_ready;
    assign rf_wd    = in_data;
    assign out_data = rf_rd1;
    assign rf_ra1   = idx;
    assign rf_wa    = idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            rf_wrap   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rf_wrap   <= win;
                        idx       <= 2'd0;
                        busy      <= 1'b1;
                        out_valid <= !op;
                        in_ready  <= op;
                        state     <= op ? FILL : SPILL;
                    end
                end
                SPILL: begin
                    if (spill_hs) begin
                        if (idx == LAST) begin
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                FILL: begin
                    if (rf_we) begin
                        if (idx == LAST) begin
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_spill_fill.sv
// tb/tb_rf_spill_fill.sv - scoreboard bench for rf_spill_fill against a window-array reference model
module tb_rf_spill_fill;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [1:0]   win = 2'd0;
    logic         busy, done, rf_we, out_valid, in_ready;
    logic [1:0]   rf_wrap, rf_ra1, rf_wa;
    logic [W-1:0] rf_rd1, rf_wd, out_data;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;

    rf_spill_fill #(.WIDTH(W), .REGS(4)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .win(win),
        .busy(busy), .done(done), .rf_wrap(rf_wrap), .rf_ra1(rf_ra1), .rf_rd1(rf_rd1),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 clock = ~clock;

    // Register file seen by the DUT, and the reference contents the bench expects it to hold.
    logic [W-1:0] mem     [4][4];
    logic [W-1:0] ref_mem [4][4];
    assign rf_rd1 = mem[rf_wrap][rf_ra1];
    always @(posedge clock) if (rf_we) mem[rf_wrap][rf_wa] <= rf_wd;

    typedef struct packed { logic [1:0] w; logic [1:0] i; logic [W-1:0] d; } wr_t;
    typedef struct packed { logic [1:0] w; logic [W-1:0] d; } rd_t;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    wr_t e_wr;
    rd_t e_rd;

    int checks = 0;
    int errors = 0;
    logic         stalled = 1'b0;
    logic [W-1:0] held = '0;
    logic         prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            stalled   <= 1'b0;
            prev_done <= 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(held));
            end
            if (out_valid && out_ready) begin
                chk("spill_word_expected", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) begin
                    e_rd = exp_rd.pop_front();
                    chk("spill_data", 32'(out_data), 32'(e_rd.d));
                    chk("spill_wrap", 32'(rf_wrap), 32'(e_rd.w));
                end
            end
            if (rf_we) begin
                chk("fill_word_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    e_wr = exp_wr.pop_front();
                    chk("fill_wa", 32'(rf_wa), 32'(e_wr.i));
                    chk("fill_wd", 32'(rf_wd), 32'(e_wr.d));
                    chk("fill_wrap", 32'(rf_wrap), 32'(e_wr.w));
                end
            end
            if (done) begin
                chk("done_width", 32'(prev_done), 32'd0);
                chk("done_not_busy", 32'(busy), 32'd0);
            end
            stalled   <= out_valid && !out_ready;
            held      <= out_data;
            prev_done <= done;
        end
    end

    // mode: 0 = always ready, 1 = ready toggles 1,0,1,0, 2 = random; poke = stray fill request mid-spill.
    task automatic do_spill(input logic [1:0] w, input int mode, input bit poke, input bit check_lat);
        int cyc;
        bit got;
        for (int i = 0; i < 4; i++) exp_rd.push_back('{w, ref_mem[w][i]});
        start = 1'b1; op = 1'b0; win = w;
        @(posedge clock); #1;
        start = 1'b0; op = 1'($urandom); win = 2'($urandom);
        cyc = 1; got = 1'b0;
        while (!got && cyc < 100) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && cyc == 2) begin start = 1'b1; op = 1'b1; end
            else start = 1'b0;
            @(negedge clock);
            if (done) got = 1'b1;
            @(posedge clock); #1;
            if (!got) cyc++;
        end
        start = 1'b0; out_ready = 1'b0;
        chk("spill_done_seen", 32'(got), 32'd1);
        if (check_lat) chk("spill_latency", 32'(cyc), 32'd5);
        chk("spill_all_words", 32'(exp_rd.size()), 32'd0);
        chk("spill_idle_after", 32'(busy), 32'd0);
        chk("spill_wrap_held", 32'(rf_wrap), 32'(w));
        exp_rd.delete();
    endtask

    // gaps: 0 = valid every cycle, 1 = alternating, 2 = random; directed uses 0xA000+k.
    task automatic do_fill(input logic [1:0] w, input int gaps, input bit directed);
        int cyc, k;
        bit got, v;
        start = 1'b1; op = 1'b1; win = w;
        @(posedge clock); #1;
        start = 1'b0; op = 1'($urandom); win = 2'($urandom);
        cyc = 1; k = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            case (gaps)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = directed ? W'(16'hA000 + k) : W'($urandom);
            if (k < 4 && v) begin
                exp_wr.push_back('{w, 2'(k), in_data});
                ref_mem[w][k] = in_data;
                k++;
            end
            @(negedge clock);
            if (done) got = 1'b1;
            @(posedge clock); #1;
            if (!got) cyc++;
        end
        in_valid = 1'b0;
        chk("fill_done_seen", 32'(got), 32'd1);
        chk("fill_all_words", 32'(exp_wr.size()), 32'd0);
        chk("fill_idle_after", 32'(busy), 32'd0);
        chk("fill_wrap_held", 32'(rf_wrap), 32'(w));
        exp_wr.delete();
    endtask

    initial begin
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 4; i++) begin
                mem[w][i]     = (w == 2) ? W'(16'h1111 * (i + 1)) : W'($urandom);
                ref_mem[w][i] = mem[w][i];
            end

        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wrap", 32'(rf_wrap), 32'd0);
        chk("rst_idx", 32'(rf_ra1), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        do_spill(2'd2, 0, 1'b0, 1'b1);
        do_spill(2'd2, 1, 1'b0, 1'b0);
        do_fill(2'd1, 1, 1'b1);
        do_spill(2'd1, 2, 1'b1, 1'b0);

        // Abort a fill after two accepted words; those two stay written.
        start = 1'b1; op = 1'b1; win = 2'd3;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            exp_wr.push_back('{2'd3, 2'(k), in_data});
            ref_mem[3][k] = in_data;
            @(posedge clock); #1;
        end
        in_data = W'($urandom);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(rf_we), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_wrap", 32'(rf_wrap), 32'd0);
        chk("abort_writes", 32'(exp_wr.size()), 32'd0);
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_wr.delete();
        @(posedge clock); #1;

        do_spill(2'd3, 0, 1'b0, 1'b1);
        do_fill(2'd3, 0, 1'b0);
        do_spill(2'd3, 2, 1'b0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 1) do_fill(2'($urandom), 2, 1'b0);
            else do_spill(2'($urandom), 2, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
